// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss-refill controller: AXI4 line fetch into the data array, tag invalidate/validate
module icache_refill #(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        miss_req,
   input  logic [31:0] miss_addr,
   input  logic        tag_ready,
   output logic        busy,
   output logic        refill_done,
   output logic        refill_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        data_wen,
   output logic [9:0]  data_waddr,
   output logic [31:0] data_wdata,
   output logic [3:0]  tag_wen,
   output logic [31:0] tag_waddr,
   output logic [20:0] tag_wdata
);

   localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INVAL,
      S_AR,
      S_R,
      S_TAG,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic [26:0] line;
   logic [2:0]  cnt;
   logic        err;
   logic        beat;
   logic        beat_bad;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^miss_addr[4:0];

   assign beat = (state == S_R) && rvalid;

   // An 8th beat without rlast means the slave is overrunning the line.
   assign beat_bad = (rresp != 2'b00) || (rid != AXI_ID)
                   || ( rlast && (cnt != LAST_WORD))
                   || (!rlast && (cnt == LAST_WORD));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         line  <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == S_IDLE) && miss_req && tag_ready) begin
            line <= miss_addr[31:5];
            cnt  <= '0;
            err  <= 1'b0;
         end
         if (beat) begin
            cnt <= cnt + 3'd1;
            if (beat_bad) begin
               err <= 1'b1;
            end
         end
      end
   end

   assign tag_waddr = {line, 5'b0};

   always_comb begin
      state_nx    = state;
      busy        = 1'b1;
      refill_done = 1'b0;
      refill_err  = 1'b0;
      arid        = 4'd0;
      araddr      = 32'd0;
      arlen       = 8'd0;
      arsize      = 3'd0;
      arburst     = 2'd0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      data_wen    = 1'b0;
      data_waddr  = 10'd0;
      data_wdata  = 32'd0;
      tag_wen     = 4'h0;
      tag_wdata   = 21'd0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (miss_req && tag_ready) begin
               state_nx = S_INVAL;
            end
         end
         S_INVAL: begin
            // Kill the old tag before any data word is overwritten.
            tag_wen  = 4'hF;
            state_nx = S_AR;
         end
         S_AR: begin
            arvalid = 1'b1;
            arid    = AXI_ID;
            araddr  = {line, 5'b0};
            arlen   = 8'(LINE_WORDS - 1);
            arsize  = 3'd2;
            arburst = 2'b01;
            if (arready) begin
               state_nx = S_R;
            end
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) begin
               data_wen   = 1'b1;
               data_waddr = {line[6:0], cnt};
               data_wdata = rdata;
               if (rlast) begin
                  state_nx = S_TAG;
               end
            end
         end
         S_TAG: begin
            if (!err) begin
               tag_wen   = 4'hF;
               tag_wdata = {1'b1, line[26:7]};
            end
            state_nx = S_DONE;
         end
         S_DONE: begin
            refill_done = 1'b1;
            refill_err  = err;
            state_nx    = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed bench for icache_refill with a cycle-stepped AXI slave model
module tb_icache_refill;

   logic        clk = 1'b0;
   logic        resetn;
   logic        miss_req;
   logic [31:0] miss_addr;
   logic        tag_ready;
   logic        busy, refill_done, refill_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        data_wen;
   logic [9:0]  data_waddr;
   logic [31:0] data_wdata;
   logic [3:0]  tag_wen;
   logic [31:0] tag_waddr;
   logic [20:0] tag_wdata;

   int checks = 0;
   int errors = 0;

   icache_refill dut (
      .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_addr(miss_addr),
      .tag_ready(tag_ready), .busy(busy), .refill_done(refill_done), .refill_err(refill_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .data_wen(data_wen),
      .data_waddr(data_waddr), .data_wdata(data_wdata), .tag_wen(tag_wen),
      .tag_waddr(tag_waddr), .tag_wdata(tag_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_slave();
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      rdata   = 32'd0;
      rid     = 4'd0;
   endtask

   // One refill from acceptance to refill_done; cycle 0 is the IDLE acceptance edge.
   task automatic run_refill(input logic [31:0] addr, input int ar_wait, input bit gaps,
                             input int err_beat, input int last_beat, input int abort_beat,
                             input bit exp_err, input int exp_cycles);
      int k, b, ar_left, invals, valids, writes;
      bit phase, done_seen;
      logic [6:0]  idx;
      logic [20:0] exp_tag;
      idx     = addr[11:5];
      exp_tag = {1'b1, addr[31:12]};
      k = 0; b = 0; ar_left = ar_wait; invals = 0; valids = 0; writes = 0;
      phase = 1'b0; done_seen = 1'b0;
      @(negedge clk);
      miss_addr = addr;
      miss_req  = 1'b1;
      tag_ready = 1'b1;
      while (k < 200 && !done_seen) begin
         @(negedge clk);
         k++;
         miss_req = 1'b0;
         clear_slave();
         if (arvalid) begin
            check_eq("araddr", araddr, {addr[31:5], 5'b0});
            check_eq("arlen", arlen, 8'd7);
            check_eq("arsize", arsize, 3'd2);
            check_eq("arburst", arburst, 2'b01);
            check_eq("arid", arid, 4'd0);
            if (ar_left > 0) ar_left--;
            else arready = 1'b1;
         end
         if (rready) begin
            if (!(gaps && phase)) begin
               rvalid = 1'b1;
               rdata  = 32'h100 + 32'(b);
               rresp  = (b == err_beat) ? 2'b10 : 2'b00;
               rlast  = (b == last_beat);
            end
            phase = !phase;
         end
         #1;
         check_eq("data_wen", data_wen, rvalid);
         if (rvalid) begin
            check_eq("data_waddr", data_waddr, {idx, 3'(b)});
            check_eq("data_wdata", data_wdata, 32'h100 + 32'(b));
            writes++;
            b++;
            if (abort_beat > 0 && b == abort_beat) begin
               resetn = 1'b0;
               #1;
               check_eq("rst_rready", rready, 1'b0);
               check_eq("rst_arvalid", arvalid, 1'b0);
               check_eq("rst_busy", busy, 1'b0);
               check_eq("rst_data_wen", data_wen, 1'b0);
               return;
            end
         end
         if (k == 1) begin
            check_eq("inval_wen", tag_wen, 4'hF);
            check_eq("inval_wdata", tag_wdata, 21'd0);
         end
         if (tag_wen != 4'h0) begin
            check_eq("tag_wen_val", tag_wen, 4'hF);
            check_eq("tag_vs_data", data_wen, 1'b0);
            check_eq("tag_index", tag_waddr[11:5], idx);
            if (tag_wdata == 21'd0) invals++;
            else begin
               valids++;
               check_eq("tag_wdata", tag_wdata, exp_tag);
            end
         end
         if (refill_done) begin
            done_seen = 1'b1;
            check_eq("done_cycle", k, exp_cycles);
            check_eq("refill_err", refill_err, exp_err);
         end
      end
      check_eq("done_seen", done_seen, 1'b1);
      check_eq("inval_count", invals, 1);
      check_eq("valid_count", valids, exp_err ? 0 : 1);
      check_eq("write_count", writes, last_beat + 1);
      clear_slave();
      @(negedge clk);
      check_eq("back_idle", busy, 1'b0);
   endtask

   initial begin
      resetn    = 1'b0;
      miss_req  = 1'b0;
      miss_addr = 32'd0;
      tag_ready = 1'b0;
      clear_slave();
      repeat (3) @(negedge clk);
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_arvalid", arvalid, 1'b0);
      check_eq("reset_rready", rready, 1'b0);
      check_eq("reset_tag_wen", tag_wen, 4'h0);
      check_eq("reset_data_wen", data_wen, 1'b0);
      check_eq("reset_done", refill_done, 1'b0);
      check_eq("reset_araddr", araddr, 32'd0);
      resetn = 1'b1;

      // Init gating: request pending while the tag array is still clearing.
      miss_req  = 1'b1;
      miss_addr = 32'h0000_4E60;
      for (int i = 0; i < 127; i++) begin
         @(negedge clk);
         check_eq("gate_busy", busy, 1'b0);
         check_eq("gate_arvalid", arvalid, 1'b0);
      end
      run_refill(32'h0000_4E60, 0, 1'b0, -1, 7, 0, 1'b0, 12);

      // Basic refill.
      run_refill(32'hBFC0_1234, 0, 1'b0, -1, 7, 0, 1'b0, 12);

      // Backpressure: 3 cycles of arready low, rvalid alternating 1/0.
      run_refill(32'h8000_0FE0, 3, 1'b1, -1, 7, 0, 1'b0, 22);

      // Slave error on beat 4.
      run_refill(32'h1234_5678, 0, 1'b0, 3, 7, 0, 1'b1, 12);

      // Short burst: rlast on beat 5.
      run_refill(32'hCAFE_0040, 0, 1'b0, -1, 4, 0, 1'b1, 9);

      // Asynchronous reset after beat 3, then a clean refill.
      run_refill(32'hDEAD_BEE0, 0, 1'b0, -1, 7, 3, 1'b0, 12);
      clear_slave();
      miss_req = 1'b0;
      @(negedge clk);
      check_eq("held_busy", busy, 1'b0);
      resetn = 1'b1;
      run_refill(32'h0000_0FA0, 0, 1'b0, -1, 7, 0, 1'b0, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
